fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32I core. Holds the program counter, issues one-at-a-time requests to instruction memory over a req/gnt/rvalid handshake, and presents fetched instructions to decode through a one-entry valid/ready buffer. Consumes the branch comparator's `result` together with jump decode from execute, computes the redirect target, and discards wrong-path fetches.

## Interface
- `DataWidth`, 32, address/data width
- `ResetVector`, 32'h0000_0000, first fetch address after reset

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `br_taken`  in  1  branch comparator result (already gated by its enable)
- `jal`  in  1  execute holds a JAL
- `jalr`  in  1  execute holds a JALR
- `ex_pc`  in  DataWidth  PC of the instruction in execute
- `imm`  in  DataWidth  sign-extended B/J/I immediate
- `rs1_data`  in  DataWidth  JALR base register
- `stall`  in  1  hazard unit: start no new fetch
- `imem_req`  out  1  memory request
- `imem_addr`  out  DataWidth  request address
- `imem_gnt`  in  1  request accepted
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  DataWidth  read data
- `if_valid`  out  1  instruction available to decode
- `if_ready`  in  1  decode accepts
- `if_instr`  out  DataWidth  instruction word
- `if_pc`  out  DataWidth  PC of `if_instr`
- `trap_misalign`  out  1  one-cycle pulse: redirect target not 4-byte aligned

## Operation
- `redirect = br_taken | jal | jalr`. Priority jalr > jal > branch.
- Target: jalr -> `(rs1_data + imm) & ~1`; jal/branch -> `ex_pc + imm`. Addition wraps modulo 2^DataWidth.
- Misaligned target (bit 1 set): no redirect, PC and FSM unaffected, `trap_misalign` high next cycle for exactly one cycle.
- Registers: `pc` (next fetch address), `req_pc` (address of outstanding request), `drop` (outstanding response is stale), output buffer.
- `buf_free = !if_valid | (if_valid & if_ready)`.
- States:
  - IDLE: `imem_req=0`. Go to REQ when `buf_free & !stall & !redirect`.
  - REQ: `imem_req=1`, `imem_addr=pc`. On `imem_gnt`: `req_pc<=pc`, `pc<=pc+4`, go to WAIT. `stall` does not withdraw a pending request.
  - WAIT: `imem_req=0`. On `imem_rvalid`: if `drop`, discard and clear `drop`; else `if_valid<=1`, `if_instr<=imem_rdata`, `if_pc<=req_pc`. Go to IDLE.
- Valid aligned redirect (overrides stall, all states):
  - `pc<=target`, `if_valid<=0`.
  - REQ without gnt: stay in REQ; `imem_addr` shows the target next cycle. This is the only permitted address change while `imem_req` is high.
  - REQ with gnt: go to WAIT with `drop<=1`. `pc<=target`, not `pc+4`.
  - WAIT without rvalid: `drop<=1`.
  - WAIT with rvalid: response discarded, go to IDLE.
  - IDLE: stay in IDLE this cycle.
- At most one outstanding request. A request is issued only when the buffer is free, so a response never finds the buffer full.
- Pop: `if_valid & if_ready` clears `if_valid`. `if_instr`/`if_pc` hold their values until the next load.

## Timing
- Reset (`rst_n` low at an edge): state IDLE, `pc=ResetVector`, `drop=0`, `imem_req=0`, `imem_addr=ResetVector`, `if_valid=0`, `if_instr=0`, `if_pc=0`, `trap_misalign=0`. Reset mid-transaction abandons any outstanding request. A late `imem_rvalid` in IDLE is ignored.
- First `imem_req` is asserted in the cycle after the first edge with `rst_n` high.
- Redirect sampled at edge N: new address on `imem_addr` from cycle N+1 (REQ) or N+2 (IDLE).
- gnt at edge t, rvalid at edge t+k: `if_valid` high in cycle t+k+1.
- Peak throughput: one instruction per 3 cycles with 1-cycle memory latency.

## Test plan
- Reset release, gnt immediate, rvalid 1 cycle later, `if_ready=1`: addresses 0x0, 0x4, 0x8 issued; `if_pc` 0x0/0x4/0x8 paired with the matching rdata.
- `br_taken=1`, `ex_pc=0x100`, `imm=0x20`, arriving while in WAIT: the in-flight response is discarded, the next request goes to 0x120, and the first `if_pc` after it is 0x120.
- `jalr=1`, `rs1_data=0x203`, `imm=0`: target 0x202 is misaligned, so `trap_misalign` pulses one cycle and fetch continues sequentially. With `rs1_data=0x201`: target 0x200 is taken.
- `if_ready=0` with the buffer full: no new `imem_req` until a pop. `stall=1` in IDLE keeps `imem_req` low. `stall` raised in REQ keeps `imem_req` high until gnt.
- Redirect in the same cycle as gnt (target 0x400): `drop` is set, the stale rvalid produces no `if_valid`, and the next request is to 0x400.
- `rst_n` low while in WAIT: all outputs return to their reset values and the first request afterwards goes to ResetVector.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus and fetch-to-decode valid/ready handshake.
interface fetch_unit_if #(
   parameter int unsigned DataWidth = 32
);
   logic                 imem_req;
   logic [DataWidth-1:0] imem_addr;
   logic                 imem_gnt;
   logic                 imem_rvalid;
   logic [DataWidth-1:0] imem_rdata;
   logic                 if_valid;
   logic                 if_ready;
   logic [DataWidth-1:0] if_instr;
   logic [DataWidth-1:0] if_pc;

   // fetch side
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata,
      output if_valid,
      output if_instr,
      output if_pc,
      input  if_ready
   );

   // memory and decode side
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata,
      input  if_valid,
      input  if_instr,
      input  if_pc,
      output if_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding imem requests, one-entry decode buffer,
// redirect on branch/jump with wrong-path response squashing.
module fetch_unit #(
   parameter int unsigned          DataWidth   = 32,
   parameter logic [DataWidth-1:0] ResetVector = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 br_taken,
   input  logic                 jal,
   input  logic                 jalr,
   input  logic [DataWidth-1:0] ex_pc,
   input  logic [DataWidth-1:0] imm,
   input  logic [DataWidth-1:0] rs1_data,
   input  logic                 stall,
   fetch_unit_if.master         bus,
   output logic                 trap_misalign
);

   localparam int unsigned InstrBytes = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [DataWidth-1:0] pc_q, pc_d;
   logic [DataWidth-1:0] req_pc_q, req_pc_d;
   logic                 drop_q, drop_d;
   logic                 if_valid_q, if_valid_d;
   logic [DataWidth-1:0] if_instr_q, if_instr_d;
   logic [DataWidth-1:0] if_pc_q, if_pc_d;
   logic                 imem_req_q, imem_req_d;
   logic [DataWidth-1:0] imem_addr_q, imem_addr_d;
   logic                 trap_q, trap_d;

   logic [DataWidth-1:0] jalr_sum;
   logic [DataWidth-1:0] target;
   logic                 redirect;
   logic                 redir_ok;
   logic                 misalign;
   logic                 buf_free;

   // Redirect target and qualification; jal and branch share ex_pc + imm.
   always_comb begin
      jalr_sum = rs1_data + imm;
      target   = ex_pc + imm;
      if (jalr) begin
         target = jalr_sum & ~DataWidth'(1);
      end
      redirect = br_taken | jal | jalr;
      misalign = redirect & target[1];
      redir_ok = redirect & ~target[1];
      buf_free = ~if_valid_q | bus.if_ready;
   end

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      drop_d     = drop_q;
      if_valid_d = if_valid_q & ~bus.if_ready;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;

      unique case (state_q)
         S_IDLE: begin
            if (buf_free && !stall && !redir_ok) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.imem_gnt) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + DataWidth'(InstrBytes);
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               if (!drop_q && !redir_ok) begin
                  if_valid_d = 1'b1;
                  if_instr_d = bus.imem_rdata;
                  if_pc_d    = req_pc_q;
               end
               drop_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A taken redirect wins over stall and marks any in-flight response stale.
      if (redir_ok) begin
         pc_d       = target;
         if_valid_d = 1'b0;
         if (state_q == S_REQ && bus.imem_gnt) begin
            drop_d = 1'b1;
         end else if (state_q == S_WAIT) begin
            drop_d = ~bus.imem_rvalid;
         end
      end

      imem_req_d  = (state_d == S_REQ);
      imem_addr_d = pc_d;
      trap_d      = misalign;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= ResetVector;
         req_pc_q    <= ResetVector;
         drop_q      <= 1'b0;
         if_valid_q  <= 1'b0;
         if_instr_q  <= '0;
         if_pc_q     <= '0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= ResetVector;
         trap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         drop_q      <= drop_d;
         if_valid_q  <= if_valid_d;
         if_instr_q  <= if_instr_d;
         if_pc_q     <= if_pc_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         trap_q      <= trap_d;
      end
   end

   assign bus.imem_req   = imem_req_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.if_valid   = if_valid_q;
   assign bus.if_instr   = if_instr_q;
   assign bus.if_pc      = if_pc_q;
   assign trap_misalign  = trap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, transaction-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        br_taken, jal, jalr, stall;
   logic [31:0] ex_pc, imm, rs1_data;
   logic        trap_misalign;

   fetch_unit_if #(.DataWidth(32)) bus ();

   fetch_unit #(.DataWidth(32), .ResetVector(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .br_taken      (br_taken),
      .jal           (jal),
      .jalr          (jalr),
      .ex_pc         (ex_pc),
      .imm           (imm),
      .rs1_data      (rs1_data),
      .stall         (stall),
      .bus           (bus),
      .trap_misalign (trap_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], 16'h0013};
   endfunction

   // memory controls (written by stimulus)
   bit gnt_en = 1'b1;
   int lat    = 1;

   // memory state and observation log (written by the negedge process)
   bit          pend     = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;
   bit          gnt_now  = 1'b0;
   int          cyc_no   = 0;
   int          trap_cnt = 0;
   logic [31:0] got_addr[$];
   int          got_gcyc[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_in[$];

   // reference model: expected bus and buffer contents for the current cycle
   bit          m_init = 1'b0;
   bit          m_req, m_out, m_stale, m_valid, m_trap;
   logic [31:0] m_next_addr, m_out_addr, m_pc, m_instr;

   always @(negedge clk) begin : model_p
      logic        rv, gn, redir, ok, free;
      logic [31:0] tgt;
      cyc_no++;

      if (m_init) begin
         check("imem_req", 32'(bus.imem_req), 32'(m_req));
         if (m_req) check("imem_addr", bus.imem_addr, m_next_addr);
         check("if_valid", 32'(bus.if_valid), 32'(m_valid));
         check("if_pc", bus.if_pc, m_pc);
         check("if_instr", bus.if_instr, m_instr);
         check("trap_misalign", 32'(trap_misalign), 32'(m_trap));
      end
      if (bus.if_valid && bus.if_ready) begin
         got_pc.push_back(bus.if_pc);
         got_in.push_back(bus.if_instr);
      end
      if (trap_misalign) trap_cnt++;

      // memory: grant one request at a time, answer lat edges after the grant
      rv = 1'b0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt <= 0) begin
            rv   = 1'b1;
            pend = 1'b0;
         end
      end
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      gn = gnt_en && bus.imem_req && !pend && !rv;
      if (gn) begin
         pend      = 1'b1;
         pend_cnt  = lat;
         pend_addr = bus.imem_addr;
         got_addr.push_back(bus.imem_addr);
         got_gcyc.push_back(cyc_no);
      end
      bus.imem_gnt = gn;
      gnt_now      = gn;

      // expected state after the coming edge
      if (!rst_n) begin
         m_init = 1'b1; m_req = 1'b0; m_out = 1'b0; m_stale = 1'b0;
         m_valid = 1'b0; m_trap = 1'b0; m_next_addr = 32'h0;
         m_out_addr = 32'h0; m_pc = 32'h0; m_instr = 32'h0;
      end else if (m_init) begin
         redir  = br_taken | jal | jalr;
         tgt    = jalr ? ((rs1_data + imm) & ~32'd1) : (ex_pc + imm);
         ok     = redir && !tgt[1];
         m_trap = redir && tgt[1];
         free   = !m_valid || bus.if_ready;
         if (m_valid && bus.if_ready) m_valid = 1'b0;
         if (m_req) begin
            if (gn) begin
               m_req = 1'b0; m_out = 1'b1;
               m_out_addr  = m_next_addr;
               m_next_addr = m_next_addr + 32'd4;
            end
         end else if (m_out) begin
            if (rv) begin
               if (!m_stale && !ok) begin
                  m_valid = 1'b1; m_pc = m_out_addr; m_instr = mem_word(m_out_addr);
               end
               m_out = 1'b0; m_stale = 1'b0;
            end
         end else if (free && !stall && !ok) begin
            m_req = 1'b1;
         end
         if (ok) begin
            m_next_addr = tgt;
            m_valid     = 1'b0;
            if (m_out) m_stale = 1'b1;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pops(input int target, input string what);
      int k = 0;
      while (got_pc.size() < target && k < 60) begin cyc(1); k++; end
      check({what, "_pops"}, 32'(got_pc.size()), 32'(target));
   endtask

   task automatic wait_grant(input string what);
      int k = 0;
      do begin cyc(1); k++; end while (!gnt_now && k < 60);
      check({what, "_grant"}, 32'(gnt_now), 32'd1);
   endtask

   task automatic wait_req(input string what);
      int k = 0;
      do begin cyc(1); k++; end while (!bus.imem_req && k < 60);
      check({what, "_req"}, 32'(bus.imem_req), 32'd1);
   endtask

   initial begin : stim
      int bp, ba, bt;
      logic [31:0] held;
      rst_n = 1'b0; br_taken = 1'b0; jal = 1'b0; jalr = 1'b0; stall = 1'b0;
      ex_pc = '0; imm = '0; rs1_data = '0; bus.if_ready = 1'b1;
      cyc(2);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_addr", bus.imem_addr, 32'h0);
      check("rst_valid", 32'(bus.if_valid), 32'd0);
      check("rst_pc", bus.if_pc, 32'h0);

      // sequential fetch from the reset vector
      rst_n = 1'b1;
      bp = got_pc.size(); ba = got_addr.size();
      cyc(1);
      check("t1_first_req", 32'(bus.imem_req), 32'd1);
      check("t1_first_addr", bus.imem_addr, 32'h0);
      wait_pops(bp + 3, "t1");
      check("t1_addr1", got_addr[ba+1], 32'h4);
      check("t1_addr2", got_addr[ba+2], 32'h8);
      check("t1_pc0", got_pc[bp], 32'h0);
      check("t1_pc1", got_pc[bp+1], 32'h4);
      check("t1_pc2", got_pc[bp+2], 32'h8);
      check("t1_instr1", got_in[bp+1], 32'h0004_0013);
      check("t1_rate", 32'(got_gcyc[ba+1] - got_gcyc[ba]), 32'd3);

      // taken branch while waiting on memory
      lat = 3;
      wait_grant("t2");
      br_taken = 1'b1; ex_pc = 32'h100; imm = 32'h20;
      cyc(1);
      br_taken = 1'b0;
      bp = got_pc.size(); ba = got_addr.size();
      wait_pops(bp + 1, "t2");
      check("t2_addr", got_addr[ba], 32'h120);
      check("t2_pc", got_pc[bp], 32'h120);
      check("t2_instr", got_in[bp], 32'h0120_0013);
      lat = 1;

      // misaligned jalr traps, aligned jalr redirects
      cyc(4);
      bt = trap_cnt;
      jalr = 1'b1; rs1_data = 32'h203; imm = 32'h0;
      cyc(1);
      jalr = 1'b0;
      bp = got_pc.size();
      wait_pops(bp + 2, "t3a");
      check("t3_trap_cnt", 32'(trap_cnt - bt), 32'd1);
      check("t3_seq", got_pc[bp+1] - got_pc[bp], 32'h4);
      jalr = 1'b1; rs1_data = 32'h201;
      cyc(1);
      jalr = 1'b0;
      bp = got_pc.size(); ba = got_addr.size();
      wait_pops(bp + 1, "t3b");
      check("t3_jalr_addr", got_addr[ba], 32'h200);
      check("t3_jalr_pc", got_pc[bp], 32'h200);

      // back-pressure and stall
      bus.if_ready = 1'b0;
      cyc(15);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("t4_full_noreq", 32'(bus.imem_req), 32'd0);
      end
      check("t4_full_valid", 32'(bus.if_valid), 32'd1);
      stall = 1'b1; bus.if_ready = 1'b1;
      cyc(1);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("t4_stall_noreq", 32'(bus.imem_req), 32'd0);
      end
      stall = 1'b0;
      wait_req("t4");
      gnt_en = 1'b0; stall = 1'b1; held = bus.imem_addr;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         check("t4_hold_req", 32'(bus.imem_req), 32'd1);
         check("t4_hold_addr", bus.imem_addr, held);
      end
      gnt_en = 1'b1; stall = 1'b0;
      cyc(6);

      // redirect in the same cycle as the grant
      gnt_en = 1'b0;
      wait_req("t5");
      gnt_en = 1'b1; jal = 1'b1; ex_pc = 32'h3F0; imm = 32'h10;
      cyc(1);
      jal = 1'b0;
      check("t5_gnt_same", 32'(gnt_now), 32'd1);
      bp = got_pc.size(); ba = got_addr.size();
      wait_pops(bp + 1, "t5");
      check("t5_addr", got_addr[ba], 32'h400);
      check("t5_pc", got_pc[bp], 32'h400);
      check("t5_instr", got_in[bp], 32'h0400_0013);

      // reset while a response is outstanding; late response lands in IDLE
      lat = 2;
      wait_grant("t6");
      rst_n = 1'b0;
      cyc(1);
      check("t6_rst_req", 32'(bus.imem_req), 32'd0);
      check("t6_rst_addr", bus.imem_addr, 32'h0);
      check("t6_rst_valid", 32'(bus.if_valid), 32'd0);
      check("t6_rst_instr", bus.if_instr, 32'h0);
      check("t6_rst_pc", bus.if_pc, 32'h0);
      check("t6_rst_trap", 32'(trap_misalign), 32'd0);
      rst_n = 1'b1;
      bp = got_pc.size(); ba = got_addr.size();
      wait_pops(bp + 1, "t6");
      check("t6_addr", got_addr[ba], 32'h0);
      check("t6_pc", got_pc[bp], 32'h0);
      check("t6_instr", got_in[bp], 32'h0000_0013);

      cyc(8);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
